issue_scoreboard: RTL and testbench

Issue controller between the decoder and the execute stage. It tracks outstanding register writes in a per-register pending-count scoreboard and holds the decoded instruction while a source register is still pending (RAW) or the write-count would overflow. It releases the instruction to execute once hazards clear and execute is ready. It also counts stall cycles for performance monitoring.

---
 rtl/issue_scoreboard_if.sv | 31 +++
 rtl/issue_scoreboard.sv | 101 ++++++++++
 tb/tb_issue_scoreboard.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/issue_scoreboard_if.sv
// Decoder / execute / write-back signal bundle for the issue scoreboard.
// The master drives the instruction slot and write-backs; the slave returns issue/stall.
interface issue_scoreboard_if;
    logic       dec_valid;
    logic       dec_en_rx;
    logic       dec_en_ry;
    logic       dec_en_w;
    logic [4:0] dec_rx_addr;
    logic [4:0] dec_ry_addr;
    logic [4:0] dec_w_addr;
    logic       ex_ready;
    logic       wb_valid;
    logic [4:0] wb_addr;
    logic       flush;
    logic       issue;
    logic       stall;

    modport master (
        output dec_valid, dec_en_rx, dec_en_ry, dec_en_w,
        output dec_rx_addr, dec_ry_addr, dec_w_addr,
        output ex_ready, wb_valid, wb_addr, flush,
        input  issue, stall
    );

    modport slave (
        input  dec_valid, dec_en_rx, dec_en_ry, dec_en_w,
        input  dec_rx_addr, dec_ry_addr, dec_w_addr,
        input  ex_ready, wb_valid, wb_addr, flush,
        output issue, stall
    );
endinterface

// File: rtl/issue_scoreboard.sv
// Issue controller: per-register pending-write counters, RAW / write-overflow hold,
// zero-latency issue to execute and a stall-cycle performance counter.
module issue_scoreboard #(
    parameter int CNT_W = 2,
    parameter int REG_N = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    issue_scoreboard_if.slave   dec_if,
    output logic                hold_state,
    output logic [31:0]         stall_cycles
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic {RUN, HOLD} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q [REG_N];
    logic [CNT_W-1:0] cnt_d [REG_N];
    logic [REG_N-1:0] inc_vec;
    logic [REG_N-1:0] dec_vec;
    logic [31:0]      stall_cycles_q;

    logic [CNT_W-1:0] cnt_rx, cnt_ry, cnt_w;
    logic             pend_x, pend_y, full_w, hazard;
    logic             issue_w, stall_w;

    assign cnt_rx = cnt_q[dec_if.dec_rx_addr];
    assign cnt_ry = cnt_q[dec_if.dec_ry_addr];
    assign cnt_w  = cnt_q[dec_if.dec_w_addr];

    // A last outstanding write retiring this cycle is bypassed through the register file.
    assign pend_x = dec_if.dec_en_rx && (cnt_rx != '0) &&
                    !(dec_if.wb_valid && (dec_if.wb_addr == dec_if.dec_rx_addr) && (cnt_rx == CNT_ONE));
    assign pend_y = dec_if.dec_en_ry && (cnt_ry != '0) &&
                    !(dec_if.wb_valid && (dec_if.wb_addr == dec_if.dec_ry_addr) && (cnt_ry == CNT_ONE));
    assign full_w = dec_if.dec_en_w && (dec_if.dec_w_addr != 5'd0) && (cnt_w == CNT_MAX) &&
                    !(dec_if.wb_valid && (dec_if.wb_addr == dec_if.dec_w_addr));
    assign hazard = pend_x || pend_y || full_w;

    assign issue_w = rdy && !rst && !dec_if.flush && dec_if.dec_valid && !hazard && dec_if.ex_ready;
    assign stall_w = rst || (dec_if.dec_valid && !dec_if.flush && (hazard || !dec_if.ex_ready));

    assign dec_if.issue = issue_w;
    assign dec_if.stall = stall_w;

    generate
        for (genvar gi = 0; gi < REG_N; gi++) begin : g_reg
            if (gi == 0) begin : g_zero
                assign inc_vec[gi] = 1'b0;
                assign dec_vec[gi] = 1'b0;
            end else begin : g_live
                assign inc_vec[gi] = issue_w && dec_if.dec_en_w && (dec_if.dec_w_addr == 5'(gi));
                assign dec_vec[gi] = dec_if.wb_valid && (dec_if.wb_addr == 5'(gi)) && (cnt_q[gi] != '0);
            end
        end
    endgenerate

    always_comb begin
        for (int r = 0; r < REG_N; r++) begin
            cnt_d[r] = cnt_q[r];
            if (inc_vec[r] && !dec_vec[r]) begin
                cnt_d[r] = cnt_q[r] + CNT_ONE;
            end else if (dec_vec[r] && !inc_vec[r]) begin
                cnt_d[r] = cnt_q[r] - CNT_ONE;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (stall_w && dec_if.dec_valid) state_d = HOLD;
            HOLD:    if (issue_w || dec_if.flush) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < REG_N; r++) begin
                cnt_q[r] <= '0;
            end
            state_q        <= RUN;
            stall_cycles_q <= '0;
        end else if (rdy) begin
            for (int r = 0; r < REG_N; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            state_q        <= state_d;
            stall_cycles_q <= stall_cycles_q + 32'(stall_w);
        end
    end

    assign hold_state   = (state_q == HOLD);
    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Self-checking bench for issue_scoreboard: per-cycle expectations are queued when
// stimulus is applied and compared against the DUT at the following negedge.
module tb_issue_scoreboard;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        hold_state;
    logic [31:0] stall_cycles;

    issue_scoreboard_if bus ();

    issue_scoreboard #(.CNT_W(2), .REG_N(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .rdy          (rdy),
        .dec_if       (bus),
        .hold_state   (hold_state),
        .stall_cycles (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit        issue;
        bit        stall;
        bit        hold;
        bit [31:0] perf;
    } exp_t;

    exp_t        expq[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          mcnt[32];
    bit          mhold;
    bit [31:0]   mperf;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_cnt(input string tag, input int r, input int exp);
        check(tag, 32'(dut.cnt_q[r]), exp);
    endtask

    function automatic bit m_pend(input bit en, input logic [4:0] a);
        return en && (a != 5'd0) && (mcnt[a] != 0) &&
               !(bus.wb_valid && (bus.wb_addr == a) && (mcnt[a] == 1));
    endfunction

    function automatic bit m_full();
        return bus.dec_en_w && (bus.dec_w_addr != 5'd0) && (mcnt[bus.dec_w_addr] == 3) &&
               !(bus.wb_valid && (bus.wb_addr == bus.dec_w_addr));
    endfunction

    task automatic idle();
        bus.dec_valid   = 1'b0;
        bus.dec_en_rx   = 1'b0;
        bus.dec_en_ry   = 1'b0;
        bus.dec_en_w    = 1'b0;
        bus.dec_rx_addr = 5'd0;
        bus.dec_ry_addr = 5'd0;
        bus.dec_w_addr  = 5'd0;
        bus.ex_ready    = 1'b1;
        bus.wb_valid    = 1'b0;
        bus.wb_addr     = 5'd0;
        bus.flush       = 1'b0;
    endtask

    task automatic instr(input bit ew, input logic [4:0] w, input bit erx, input logic [4:0] rx,
                         input bit ery, input logic [4:0] ry);
        bus.dec_valid   = 1'b1;
        bus.dec_en_w    = ew;
        bus.dec_w_addr  = w;
        bus.dec_en_rx   = erx;
        bus.dec_rx_addr = rx;
        bus.dec_en_ry   = ery;
        bus.dec_ry_addr = ry;
    endtask

    // One clock: queue the expectation, compare at negedge, then advance the model.
    task automatic tick(input string ph);
        exp_t e;
        exp_t g;
        bit   iss;
        bit   stl;
        bit   haz;
        #1;
        haz = m_pend(bus.dec_en_rx, bus.dec_rx_addr) || m_pend(bus.dec_en_ry, bus.dec_ry_addr) || m_full();
        iss = rdy && !rst && !bus.flush && bus.dec_valid && !haz && bus.ex_ready;
        stl = rst || (bus.dec_valid && !bus.flush && (haz || !bus.ex_ready));
        e.issue = iss;
        e.stall = stl;
        e.hold  = mhold;
        e.perf  = mperf;
        expq.push_back(e);
        @(negedge clk);
        if (expq.size() == 0) begin
            check({ph, ".queue"}, 32'd0, 32'd1);
        end else begin
            g = expq.pop_front();
            check({ph, ".issue"}, 32'(bus.issue), 32'(g.issue));
            check({ph, ".stall"}, 32'(bus.stall), 32'(g.stall));
            check({ph, ".hold"},  32'(hold_state), 32'(g.hold));
            check({ph, ".perf"},  stall_cycles, g.perf);
        end
        $display("%-10s t=%0t dv=%0b wb=%0b/%0d issue=%0b stall=%0b hold=%0b perf=%0d",
                 ph, $time, bus.dec_valid, bus.wb_valid, bus.wb_addr, bus.issue, bus.stall,
                 hold_state, stall_cycles);
        @(posedge clk);
        if (rst) begin
            for (int r = 0; r < 32; r++) mcnt[r] = 0;
            mhold = 1'b0;
            mperf = '0;
        end else if (rdy) begin
            for (int r = 1; r < 32; r++) begin
                bit inc_r;
                bit dec_r;
                inc_r = iss && bus.dec_en_w && (bus.dec_w_addr == 5'(r));
                dec_r = bus.wb_valid && (bus.wb_addr == 5'(r)) && (mcnt[r] != 0);
                if (inc_r && !dec_r) mcnt[r] = mcnt[r] + 1;
                else if (dec_r && !inc_r) mcnt[r] = mcnt[r] - 1;
            end
            if (!mhold) mhold = stl && bus.dec_valid;
            else if (iss || bus.flush) mhold = 1'b0;
            if (stl) mperf = mperf + 32'd1;
        end
        #1;
    endtask

    task automatic wb(input logic [4:0] a);
        bus.wb_valid = 1'b1;
        bus.wb_addr  = a;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        rdy = 1'b1;
        idle();
        @(posedge clk);
        #1;
        for (int r = 0; r < 32; r++) mcnt[r] = 0;
        mhold = 1'b0;
        mperf = '0;

        // Reset state
        tick("reset");
        chk_cnt("reset.cnt1", 1, 0);
        rst = 1'b0;

        // Independent ops issue back to back
        instr(1, 5'd1, 1, 5'd2, 1, 5'd3);
        tick("indep0");
        instr(1, 5'd4, 1, 5'd5, 1, 5'd6);
        tick("indep1");
        idle();
        tick("indep2");
        chk_cnt("indep.cnt1", 1, 1);
        chk_cnt("indep.cnt4", 4, 1);
        wb(5'd1); tick("drain1");
        wb(5'd4); tick("drain4");
        idle();
        chk_cnt("drain.cnt1", 1, 0);

        // RAW: consumer waits three cycles and issues in the write-back cycle
        instr(1, 5'd1, 0, 5'd0, 0, 5'd0);
        tick("raw_prod");
        instr(0, 5'd0, 1, 5'd1, 0, 5'd0);
        tick("raw_s0");
        tick("raw_s1");
        tick("raw_s2");
        wb(5'd1);
        tick("raw_wb");
        idle();
        check("raw.perf", stall_cycles, 32'd3);
        chk_cnt("raw.cnt1", 1, 0);

        // WAW saturation on x5
        for (int i = 0; i < 3; i++) begin
            instr(1, 5'd5, 0, 5'd0, 0, 5'd0);
            tick("waw_fill");
        end
        chk_cnt("waw.cnt5_full", 5, 3);
        tick("waw_full0");
        tick("waw_full1");
        wb(5'd5);
        tick("waw_wb");
        idle();
        chk_cnt("waw.cnt5_keep", 5, 3);
        for (int i = 0; i < 3; i++) begin
            wb(5'd5);
            tick("waw_drain");
        end
        idle();
        chk_cnt("waw.cnt5_zero", 5, 0);

        // x0 never tracked
        for (int i = 0; i < 4; i++) begin
            instr(1, 5'd0, 1, 5'd0, 1, 5'd0);
            tick("x0_op");
        end
        idle();
        wb(5'd0);
        tick("x0_wb");
        idle();
        chk_cnt("x0.cnt0", 0, 0);

        // flush while holding a reader of x7
        instr(1, 5'd7, 0, 5'd0, 0, 5'd0);
        tick("fl_prod");
        instr(0, 5'd0, 1, 5'd7, 0, 5'd0);
        tick("fl_s0");
        tick("fl_s1");
        bus.flush = 1'b1;
        tick("fl_flush");
        idle();
        tick("fl_after");
        chk_cnt("fl.cnt7", 7, 1);
        wb(5'd7);
        tick("fl_wb");
        idle();
        chk_cnt("fl.cnt7_zero", 7, 0);

        // rdy low while in HOLD: nothing moves, write-back not sampled
        instr(1, 5'd8, 0, 5'd0, 0, 5'd0);
        tick("rdy_prod");
        instr(0, 5'd0, 0, 5'd0, 1, 5'd8);
        tick("rdy_hold");
        rdy = 1'b0;
        wb(5'd8);
        for (int i = 0; i < 4; i++) tick("rdy_low");
        chk_cnt("rdy.cnt8", 8, 1);
        check("rdy.perf", stall_cycles, 32'd8);
        check("rdy.hold", 32'(hold_state), 32'd1);
        rdy = 1'b1;
        tick("rdy_back");
        idle();
        chk_cnt("rdy.cnt8_zero", 8, 0);

        // Reset discards pending counts; later write-back ignored
        instr(1, 5'd3, 0, 5'd0, 0, 5'd0);
        tick("rs_w0");
        tick("rs_w1");
        idle();
        chk_cnt("rs.cnt3", 3, 2);
        rst = 1'b1;
        tick("rs_rst");
        rst = 1'b0;
        chk_cnt("rs.cnt3_clr", 3, 0);
        check("rs.perf", stall_cycles, 32'd0);
        wb(5'd3);
        tick("rs_wb");
        idle();
        chk_cnt("rs.cnt3_wb", 3, 0);
        instr(0, 5'd0, 1, 5'd3, 0, 5'd0);
        tick("rs_read");
        idle();
        bus.dec_valid = 1'b1;
        bus.ex_ready  = 1'b0;
        tick("exr_low");
        idle();
        tick("end");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
